// File: rtl/out_ser_pkg.sv
// Shared types and helpers for the output-nibble serial link.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build with OUTSER_PARITY_EN defined to add an even-parity bit.
package out_ser_pkg;

`ifdef OUTSER_PARITY_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    // Frame states; PARITY only exists in the parity build
    typedef enum logic [STATE_W-1:0] {
        IDLE,
        START,
        DATA,
`ifdef OUTSER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Minimum register width able to hold 0..value-1 (never less than 1 bit)
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/out_ser_baud.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and wraps, pulsing o_bit_end on the last count.
// Latency: o_bit_end is combinational from the count register.
// Backpressure: none; i_clr holds the count at zero (used while the link is idle).
module out_ser_baud
    import out_ser_pkg::*;
#(
    parameter  int BIT_CYCLES = 4,
    localparam int CW         = clog2(BIT_CYCLES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_bit_end
);

    logic [CW-1:0] r_cnt;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CW'(BIT_CYCLES - 1)) && !i_clr;
    assign o_cnt     = r_cnt;
    assign o_bit_end = w_bit_end;

    // Count clocks within a bit period, restarting at each bit boundary
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/out_serializer.sv
// Serialises the latched Out nibble: start bit, data LSB first, [even parity if OUTSER_PARITY_EN], stop bit.
// Latency: TxLine/TxBusy change on the edge that accepts SendReq; each non-idle state lasts BIT_CYCLES clocks.
// Backpressure: SendReq is sampled only in IDLE; requests while busy are dropped, not queued.
module out_serializer
    import out_ser_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic              MainClock,
    input  logic              MainReset,
    input  logic [DATA_W-1:0] OutData,
    input  logic              SendReq,
    output logic              TxLine,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int CW = clog2(BIT_CYCLES);
    localparam int IW = clog2(DATA_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_nxt;
`ifdef OUTSER_PARITY_EN
    logic              r_parity;
    logic              w_parity_nxt;
`endif

    logic              r_tx_line;
    logic              r_tx_busy;
    logic              r_tx_done;
    logic              w_line_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic [CW-1:0]     w_cnt;
    logic              w_bit_end;
    logic              w_clr;

    // Counter only runs inside a frame so START always begins at count 0
    assign w_clr = (r_state == IDLE);

    out_ser_baud #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud (
        .i_clk     (MainClock),
        .i_rst     (MainReset),
        .i_clr     (w_clr),
        .o_cnt     (w_cnt),
        .o_bit_end (w_bit_end)
    );

    // Next-state, shift register and data-bit index
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_idx;
`ifdef OUTSER_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (SendReq) begin
                    w_state_nxt  = START;
                    w_shift_nxt  = OutData;
                    w_idx_nxt    = '0;
`ifdef OUTSER_PARITY_EN
                    w_parity_nxt = ^OutData;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == IW'(DATA_W - 1)) begin
                        w_idx_nxt = '0;
`ifdef OUTSER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
`ifdef OUTSER_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so the outputs can be registered
    always_comb begin
        w_line_nxt = IDLE_LEVEL;
        case (w_state_nxt)
            START:   w_line_nxt = START_LEVEL;
            DATA:    w_line_nxt = w_shift_nxt[0];
`ifdef OUTSER_PARITY_EN
            PARITY:  w_line_nxt = w_parity_nxt;
`endif
            default: w_line_nxt = IDLE_LEVEL;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
        // One count early so the registered pulse lands in the final clock of STOP
        w_done_nxt = (r_state == STOP) && (w_cnt == CW'(BIT_CYCLES - 2));
    end

    // State and output registers; reset forces the line idle immediately
    always_ff @(posedge MainClock or posedge MainReset) begin
        if (MainReset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
`ifdef OUTSER_PARITY_EN
            r_parity  <= 1'b0;
`endif
            r_tx_line <= IDLE_LEVEL;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_idx     <= w_idx_nxt;
`ifdef OUTSER_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
            r_tx_line <= w_line_nxt;
            r_tx_busy <= w_busy_nxt;
            r_tx_done <= w_done_nxt;
        end
    end

    assign TxLine = r_tx_line;
    assign TxBusy = r_tx_busy;
    assign TxDone = r_tx_done;

endmodule

// File: tb/tb_out_serializer.sv
// Directed bench for out_serializer: default build (4 clocks/bit) plus a 2 clocks/bit instance.
// Latency: n/a. Backpressure: n/a.
// Outputs sampled on the falling edge; inputs driven right after sampling.
module tb_out_serializer;

    logic       clk;
    logic       rst;
    logic [3:0] data_a;
    logic       req_a;
    logic       line_a;
    logic       busy_a;
    logic       done_a;
    logic [3:0] data_b;
    logic       req_b;
    logic       line_b;
    logic       busy_b;
    logic       done_b;

    int compared;
    int mismatched;

    out_serializer #(.DATA_W(4), .BIT_CYCLES(4)) dut (
        .MainClock (clk),
        .MainReset (rst),
        .OutData   (data_a),
        .SendReq   (req_a),
        .TxLine    (line_a),
        .TxBusy    (busy_a),
        .TxDone    (done_a)
    );

    out_serializer #(.DATA_W(4), .BIT_CYCLES(2)) dut_bc2 (
        .MainClock (clk),
        .MainReset (rst),
        .OutData   (data_b),
        .SendReq   (req_b),
        .TxLine    (line_b),
        .TxBusy    (busy_b),
        .TxDone    (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request pulse, then check every clock of the frame plus the clock after it.
    // exp_bits[i] is the i-th transmitted bit (start first).
    task automatic run_frame(input bit sel, input logic [3:0] d, input logic [6:0] exp_bits,
                             input int nbits, input int bc, input string tag);
        int   flen;
        logic l, b, dn;
        flen = nbits * bc;
        @(negedge clk);
        if (sel) begin data_b = d; req_b = 1'b1; end
        else     begin data_a = d; req_a = 1'b1; end
        for (int c = 1; c <= flen + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin req_a = 1'b0; req_b = 1'b0; end
            l  = sel ? line_b : line_a;
            b  = sel ? busy_b : busy_a;
            dn = sel ? done_b : done_a;
            if (c <= flen) begin
                check($sformatf("%s line c%0d", tag, c), l, exp_bits[(c - 1) / bc]);
                check($sformatf("%s busy c%0d", tag, c), b, 1'b1);
                check($sformatf("%s done c%0d", tag, c), dn, (c == flen) ? 1'b1 : 1'b0);
            end else begin
                check($sformatf("%s idle line", tag), l, 1'b1);
                check($sformatf("%s idle busy", tag), b, 1'b0);
                check($sformatf("%s idle done", tag), dn, 1'b0);
            end
        end
    endtask

    initial begin
        int   dones;
        logic [6:0] pat;
        compared   = 0;
        mismatched = 0;
        rst    = 1'b1;
        data_a = 4'h0;
        req_a  = 1'b0;
        data_b = 4'h0;
        req_b  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst line", line_a, 1'b1);
        check("rst busy", busy_a, 1'b0);
        check("rst done", done_a, 1'b0);
        check("rst line bc2", line_b, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 4'hA: 0,0,1,0,1,1 each 4 clocks, done at clock 24
        pat = 7'b0110100;
        run_frame(1'b0, 4'hA, pat, 6, 4, "frameA");

        // Requests while busy ignored; mid-frame OutData change has no effect
        dones = 0;
        @(negedge clk);
        data_a = 4'hA;
        req_a  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            req_a = 1'b0;
            if (done_a) dones = dones + 1;
            if (c == 6)  check("busy bit0", line_a, 1'b0);
            if (c == 10) check("busy bit1", line_a, 1'b1);
            if (c == 14) check("busy bit2", line_a, 1'b0);
            if (c == 18) check("busy bit3", line_a, 1'b1);
            if (c == 5 || c == 12) req_a = 1'b1;
            if (c == 8) data_a = 4'h3;
        end
        check("busy single done", dones, 1);
        check("busy idle after", busy_a, 1'b0);

        // Back-to-back with SendReq held high: one idle clock between frames
        @(negedge clk);
        data_a = 4'hF;
        req_a  = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 24) check("b2b done1", done_a, 1'b1);
            if (c == 25) begin
                check("b2b gap line", line_a, 1'b1);
                check("b2b gap busy", busy_a, 1'b0);
                check("b2b gap done", done_a, 1'b0);
            end
            if (c == 26) begin
                check("b2b start2 line", line_a, 1'b0);
                check("b2b start2 busy", busy_a, 1'b1);
            end
            if (c == 30) check("b2b data2 bit0", line_a, 1'b1);
            if (c == 49) check("b2b done2", done_a, 1'b1);
            if (c == 50) req_a = 1'b0;
        end
        @(negedge clk);
        check("b2b stop busy", busy_a, 1'b0);
        check("b2b stop line", line_a, 1'b1);

        // Parity-relevant patterns: 4'h7 then 4'h5
`ifdef OUTSER_PARITY_EN
        pat = 7'b1101110;
        run_frame(1'b0, 4'h7, pat, 7, 4, "frame7p");
        pat = 7'b1001010;
        run_frame(1'b0, 4'h5, pat, 7, 4, "frame5p");
`else
        pat = 7'b0101110;
        run_frame(1'b0, 4'h7, pat, 6, 4, "frame7");
        pat = 7'b0101010;
        run_frame(1'b0, 4'h5, pat, 6, 4, "frame5");
`endif

        // Two clocks per bit, 4'h1
`ifdef OUTSER_PARITY_EN
        pat = 7'b1100010;
        run_frame(1'b1, 4'h1, pat, 7, 2, "bc2p");
`else
        pat = 7'b0100010;
        run_frame(1'b1, 4'h1, pat, 6, 2, "bc2");
`endif

        // Reset mid-DATA: line idle and busy low immediately, no done afterwards
        @(negedge clk);
        data_a = 4'hA;
        req_a  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_a = 1'b0;
        end
        check("midrst pre line", line_a, 1'b1);
        check("midrst pre busy", busy_a, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst line", line_a, 1'b1);
        check("midrst busy", busy_a, 1'b0);
        check("midrst done", done_a, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_a) dones = dones + 1;
        end
        check("midrst no done", dones, 0);
        check("midrst stays idle", busy_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
